// File: rtl/mul_wb_queue_pkg.sv
// mul_wb_queue_pkg
// Shared core definitions for the multiplier writeback path: datapath widths,
// the multiplier latency and the writeback entry record that the writeback
// queues in the core store and present to the writeback arbiter.
// No ports (package).
package mul_wb_queue_pkg;

    localparam int M_WIDTH        = 64;
    localparam int LG_ROB_ENTRIES = 6;
    localparam int LG_PRF_ENTRIES = 7;
    localparam int MUL_LAT        = 3;

    // One completed operation waiting for writeback.
    typedef struct packed {
        logic [M_WIDTH-1:0]        data;
        logic [LG_ROB_ENTRIES-1:0] rob_ptr;
        logic                      prf_val;
        logic [LG_PRF_ENTRIES-1:0] prf_ptr;
    } mul_wb_entry_t;

    localparam int MUL_WB_ENTRY_W = $bits(mul_wb_entry_t);

endpackage

// File: rtl/mul_wb_queue_if.sv
// mul_wb_queue_if
// Bundles the multiplier-side signals (issue credit and completion) and the
// writeback-side handshake of the multiplier completion buffer.
//   slave  : the completion buffer (receives completions and acks, drives
//            mul_ready, the head entry fields and overflow)
//   master : the surrounding core (issue logic, multiplier, arbiter)
interface mul_wb_queue_if;
    import mul_wb_queue_pkg::*;

    logic                      mul_go;
    logic                      mul_ready;
    logic                      mul_complete;
    logic [M_WIDTH-1:0]        mul_y;
    logic [LG_ROB_ENTRIES-1:0] mul_rob_ptr;
    logic                      mul_prf_val;
    logic [LG_PRF_ENTRIES-1:0] mul_prf_ptr;

    logic                      wb_valid;
    logic                      wb_ack;
    logic [M_WIDTH-1:0]        wb_data;
    logic [LG_ROB_ENTRIES-1:0] wb_rob_ptr;
    logic                      wb_prf_val;
    logic [LG_PRF_ENTRIES-1:0] wb_prf_ptr;

    logic                      overflow;

    modport slave (
        input  mul_go, mul_complete, mul_y, mul_rob_ptr, mul_prf_val, mul_prf_ptr,
        input  wb_ack,
        output mul_ready,
        output wb_valid, wb_data, wb_rob_ptr, wb_prf_val, wb_prf_ptr,
        output overflow
    );

    modport master (
        output mul_go, mul_complete, mul_y, mul_rob_ptr, mul_prf_val, mul_prf_ptr,
        output wb_ack,
        input  mul_ready,
        input  wb_valid, wb_data, wb_rob_ptr, wb_prf_val, wb_prf_ptr,
        input  overflow
    );

endinterface

// File: rtl/mul_wb_queue_wb_fifo.sv
// wb_fifo
// Generic synchronous FIFO used by the writeback queues. Storage and pointers
// are cleared by reset so the read port shows zero until the first write.
// Ports:
//   clk, reset  : clock, synchronous active-low reset
//   push, din   : write request and data (dropped when full without a pop)
//   pop         : read request (ignored when empty)
//   dout        : head entry, valid while empty = 0
//   count       : number of stored entries (0..DEPTH)
//   full, empty : status from the registered count
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(DEPTH));
    assign count = cnt;
    assign dout  = mem[head];

    // A pop frees the head slot in the same cycle, so a push at full is
    // accepted whenever it is paired with a real pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[tail] <= din;
                tail      <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mul_wb_queue.sv
// mul_wb_queue
// Completion buffer behind the pipelined multiplier. Every completion is
// queued and offered to the writeback arbiter; issue is throttled with a
// credit signal that counts both queued results and multiplies still in the
// pipeline, so the non-stallable multiplier can never overflow the queue.
// Ports:
//   clk   : clock
//   reset : synchronous active-low reset
//   bus   : mul_wb_queue_if.slave
//           mul_go/mul_ready          issue side credit
//           mul_complete, mul_y, ...  multiplier completion
//           wb_valid/wb_ack, wb_*     writeback handshake and head entry
//           overflow                  sticky push-while-full error
module mul_wb_queue
    import mul_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LAT   = MUL_LAT + 1
) (
    input  logic          clk,
    input  logic          reset,
    mul_wb_queue_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int INF_W = $clog2(LAT + 1);
    localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

    mul_wb_entry_t    push_entry;
    mul_wb_entry_t    head_entry;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             pop_fire;
    logic [INF_W-1:0] inflight;
    logic [SUM_W-1:0] occupancy;
    logic             overflow_q;

    assign push_entry = '{
        data:    bus.mul_y,
        rob_ptr: bus.mul_rob_ptr,
        prf_val: bus.mul_prf_val,
        prf_ptr: bus.mul_prf_ptr
    };

    assign pop_fire = ~empty & bus.wb_ack;

    wb_fifo #(
        .WIDTH(MUL_WB_ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.mul_complete),
        .din   (push_entry),
        .pop   (pop_fire),
        .dout  (head_entry),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Credit check uses registered state only, so there is no combinational
    // path from wb_ack or mul_go to mul_ready.
    assign occupancy     = SUM_W'(count) + SUM_W'(inflight);
    assign bus.mul_ready = (occupancy < SUM_W'(DEPTH));

    assign bus.wb_valid   = ~empty;
    assign bus.wb_data    = head_entry.data;
    assign bus.wb_rob_ptr = head_entry.rob_ptr;
    assign bus.wb_prf_val = head_entry.prf_val;
    assign bus.wb_prf_ptr = head_entry.prf_ptr;
    assign bus.overflow   = overflow_q;

    // Inflight saturates at both ends so a protocol violation upstream cannot
    // wrap the credit count and unblock issue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (bus.mul_go && !bus.mul_complete) begin
                if (inflight != INF_W'(LAT)) begin
                    inflight <= inflight + INF_W'(1);
                end
            end else if (!bus.mul_go && bus.mul_complete) begin
                if (inflight != '0) begin
                    inflight <= inflight - INF_W'(1);
                end
            end
            if (bus.mul_complete && full && !pop_fire) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule
